// File: rtl/change_payout_unit.sv
// Coin payout engine: pays a loaded amount from three hoppers (3, 2, 1) largest coin first,
// confirms each coin on the chute sensor and bypasses hoppers that fail to confirm.
module change_payout_unit #(
    parameter int AMT_W         = 4,
    parameter int EJECT_CYCLES  = 4,
    parameter int GAP_CYCLES    = 2,
    parameter int SENSE_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [AMT_W-1:0] amount,
    input  logic [2:0]       hopper_empty,
    input  logic             coin_sensed,
    output logic             ready,
    output logic             busy,
    output logic [2:0]       eject,
    output logic [AMT_W-1:0] remaining,
    output logic             done,
    output logic             short_pay,
    output logic [2:0]       jam
);

    localparam int CNT_W = $clog2(SENSE_TIMEOUT + EJECT_CYCLES + GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_WAIT_SENSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [1:0]       coin_q, coin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             confirmed_q, confirmed_d;
    logic             short_pay_q, short_pay_d;
    logic [2:0]       jam_q, jam_d;

    logic [1:0]       pick;
    logic [AMT_W-1:0] coin_amt;

    assign coin_amt = {{(AMT_W-2){1'b0}}, coin_q};

    // Largest denomination that fits, is stocked and has not jammed; 0 when none qualifies.
    always_comb begin
        pick = 2'd0;
        if (remaining_q >= AMT_W'(3) && !hopper_empty[2] && !jam_q[2]) begin
            pick = 2'd3;
        end else if (remaining_q >= AMT_W'(2) && !hopper_empty[1] && !jam_q[1]) begin
            pick = 2'd2;
        end else if (remaining_q >= AMT_W'(1) && !hopper_empty[0] && !jam_q[0]) begin
            pick = 2'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin_d      = coin_q;
        cnt_d       = cnt_q;
        confirmed_d = confirmed_q;
        short_pay_d = short_pay_q;
        jam_d       = jam_q;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    remaining_d = amount;
                    short_pay_d = 1'b0;
                    jam_d       = 3'b000;
                    state_d     = (amount == '0) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                if (remaining_q == '0) begin
                    state_d = S_DONE;
                end else if (pick == 2'd0) begin
                    short_pay_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    coin_d      = pick;
                    cnt_d       = '0;
                    confirmed_d = 1'b0;
                    state_d     = S_EJECT;
                end
            end
            S_EJECT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Only the first sensor pulse per coin is credited.
                if (coin_sensed && !confirmed_q) begin
                    remaining_d = remaining_q - coin_amt;
                    confirmed_d = 1'b1;
                end
                if (cnt_q == CNT_W'(EJECT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (confirmed_q || coin_sensed) ? S_GAP : S_WAIT_SENSE;
                end
            end
            S_WAIT_SENSE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (coin_sensed) begin
                    remaining_d = remaining_q - coin_amt;
                    cnt_d       = '0;
                    state_d     = S_GAP;
                end else if (cnt_q == CNT_W'(SENSE_TIMEOUT - 1)) begin
                    case (coin_q)
                        2'd1:    jam_d[0] = 1'b1;
                        2'd2:    jam_d[1] = 1'b1;
                        2'd3:    jam_d[2] = 1'b1;
                        default: jam_d    = jam_q;
                    endcase
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SELECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            coin_q      <= 2'd0;
            cnt_q       <= '0;
            confirmed_q <= 1'b0;
            short_pay_q <= 1'b0;
            jam_q       <= 3'b000;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin_q      <= coin_d;
            cnt_q       <= cnt_d;
            confirmed_q <= confirmed_d;
            short_pay_q <= short_pay_d;
            jam_q       <= jam_d;
        end
    end

    // Solenoid drive decodes straight from state so it drops the instant reset asserts.
    always_comb begin
        eject = 3'b000;
        if (state_q == S_EJECT) begin
            case (coin_q)
                2'd1:    eject = 3'b001;
                2'd2:    eject = 3'b010;
                2'd3:    eject = 3'b100;
                default: eject = 3'b000;
            endcase
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign busy      = ~ready;
    assign done      = (state_q == S_DONE);
    assign remaining = remaining_q;
    assign short_pay = short_pay_q;
    assign jam       = jam_q;

endmodule

// File: tb/tb_change_payout_unit.sv
// Self-checking bench for change_payout_unit: directed scenarios plus randomized payouts
// compared against a greedy-payout reference model with per-coin timing arithmetic.
module tb_change_payout_unit;

    localparam int AMT_W = 4;
    localparam int EJ    = 4;
    localparam int GP    = 2;
    localparam int TO    = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             load;
    logic [AMT_W-1:0] amount;
    logic [2:0]       hopper_empty;
    logic             coin_sensed;
    logic             ready;
    logic             busy;
    logic [2:0]       eject;
    logic [AMT_W-1:0] remaining;
    logic             done;
    logic             short_pay;
    logic [2:0]       jam;

    int n_cmp = 0;
    int n_err = 0;

    int         exp_seq[$];
    int         exp_rem;
    int         exp_lat;
    logic       exp_short;
    logic [2:0] exp_jam;

    change_payout_unit #(
        .AMT_W(AMT_W), .EJECT_CYCLES(EJ), .GAP_CYCLES(GP), .SENSE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .amount(amount),
        .hopper_empty(hopper_empty), .coin_sensed(coin_sensed),
        .ready(ready), .busy(busy), .eject(eject), .remaining(remaining),
        .done(done), .short_pay(short_pay), .jam(jam)
    );

    always #5 clk = ~clk;

    // Greedy payout: jammed (dead) hoppers eject once, time out and are then bypassed.
    // Latency counts edges from the load edge to the edge that enters the done cycle.
    task automatic model_payout(input int amt, input logic [2:0] empty,
                                input logic [2:0] dead, input int echo);
        int rem;
        int d;
        logic [2:0] jm;
        exp_seq.delete();
        rem       = amt;
        jm        = 3'b000;
        exp_short = 1'b0;
        exp_lat   = (amt == 0) ? 0 : 1;
        while (rem > 0) begin
            d = 0;
            for (int c = 3; c >= 1; c--)
                if (d == 0 && c <= rem && !empty[c-1] && !jm[c-1]) d = c;
            if (d == 0) begin
                exp_short = 1'b1;
                break;
            end
            exp_seq.push_back(d);
            if (dead[d-1]) begin
                jm[d-1] = 1'b1;
                exp_lat += 1 + EJ + TO + GP;
            end else begin
                rem -= d;
                exp_lat += 1 + EJ + GP + ((echo >= EJ) ? (echo - EJ + 1) : 0);
            end
        end
        exp_rem = rem;
        exp_jam = jm;
    endtask

    task automatic run_payout(input string name, input int amt, input logic [2:0] empty,
                              input logic [2:0] dead, input int echo, input bit dbl,
                              input bit busy_load);
        int         obs[$];
        int         done_cnt = 0;
        int         done_at  = -1;
        int         ej_len   = 0;
        int         sense_at = -1;
        int         cur;
        logic [2:0] prev_ej  = 3'b000;
        model_payout(amt, empty, dead, echo);
        @(negedge clk);
        hopper_empty = empty;
        amount       = amt[AMT_W-1:0];
        load         = 1'b1;
        for (int j = 0; j < 800; j++) begin
            @(negedge clk);
            load        = 1'b0;
            coin_sensed = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            if (eject != 3'b000) begin
                if (prev_ej == 3'b000) begin
                    n_cmp++;
                    if ($onehot(eject) !== 1'b1) begin
                        n_err++;
                        $display("FAIL %s eject_onehot: got %b required one-hot", name, eject);
                    end
                    cur = (eject == 3'b001) ? 1 : (eject == 3'b010) ? 2 : (eject == 3'b100) ? 3 : 0;
                    obs.push_back(cur);
                    sense_at = (cur > 0 && !dead[cur-1]) ? j + echo : -1;
                    ej_len   = 0;
                end
                ej_len++;
            end else if (prev_ej != 3'b000) begin
                n_cmp++;
                if (ej_len !== EJ) begin
                    n_err++;
                    $display("FAIL %s eject_hold: got %0d cycles required %0d", name, ej_len, EJ);
                end
            end
            if (j == sense_at || (dbl && sense_at >= 0 && j == sense_at + 1) || (dbl && j == 0))
                coin_sensed = 1'b1;
            if (busy_load && busy && j < 6) begin
                load   = 1'b1;
                amount = 4'd4;
            end
            prev_ej = eject;
            if (done_at >= 0 && j >= done_at + 3) break;
        end
        load        = 1'b0;
        coin_sensed = 1'b0;

        n_cmp++;
        if (done_cnt !== 1) begin
            n_err++;
            $display("FAIL %s done_count: got %0d required 1", name, done_cnt);
        end
        n_cmp++;
        if (done_at !== exp_lat) begin
            n_err++;
            $display("FAIL %s done_latency: got %0d required %0d", name, done_at, exp_lat);
        end
        n_cmp++;
        if (obs.size() !== exp_seq.size()) begin
            n_err++;
            $display("FAIL %s coin_count: got %0d required %0d", name, obs.size(), exp_seq.size());
        end else begin
            for (int k = 0; k < obs.size(); k++) begin
                n_cmp++;
                if (obs[k] !== exp_seq[k]) begin
                    n_err++;
                    $display("FAIL %s coin[%0d]: got %0d required %0d", name, k, obs[k], exp_seq[k]);
                end
            end
        end
        n_cmp++;
        if (remaining !== exp_rem[AMT_W-1:0]) begin
            n_err++;
            $display("FAIL %s remaining: got %0d required %0d", name, remaining, exp_rem);
        end
        n_cmp++;
        if (short_pay !== exp_short) begin
            n_err++;
            $display("FAIL %s short_pay: got %b required %b", name, short_pay, exp_short);
        end
        n_cmp++;
        if (jam !== exp_jam) begin
            n_err++;
            $display("FAIL %s jam: got %b required %b", name, jam, exp_jam);
        end
        n_cmp++;
        if ({ready, busy, eject} !== 5'b10000) begin
            n_err++;
            $display("FAIL %s idle_after: got ready=%b busy=%b eject=%b required 1 0 000",
                     name, ready, busy, eject);
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        load         = 1'b0;
        amount       = '0;
        hopper_empty = 3'b000;
        coin_sensed  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ready, busy, eject, remaining, done, short_pay, jam} !== {1'b1, 1'b0, 3'b0, 4'd0, 1'b0, 1'b0, 3'b0}) begin
            n_err++;
            $display("FAIL reset_state: got ready=%b busy=%b eject=%b rem=%0d done=%b short=%b jam=%b required 1 0 000 0 0 0 000",
                     ready, busy, eject, remaining, done, short_pay, jam);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        run_payout("t1_amt7_full",      7, 3'b000, 3'b000, 2, 1'b0, 1'b0);
        run_payout("t2_amt5_no3",       5, 3'b100, 3'b000, 2, 1'b0, 1'b0);
        run_payout("t3_amt2_short",     2, 3'b011, 3'b000, 2, 1'b0, 1'b0);
        run_payout("t4_amt3_jam3",      3, 3'b000, 3'b100, 2, 1'b0, 1'b0);
        run_payout("t5_amt0_busyload",  0, 3'b000, 3'b000, 2, 1'b0, 1'b1);
        run_payout("late_echo_amt6",    6, 3'b000, 3'b000, 7, 1'b1, 1'b1);
        run_payout("max_amt15_only1",  15, 3'b110, 3'b000, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_eject();
        int ej_seen = 0;
        bit hit = 1'b0;
        int stray_done = 0;
        @(negedge clk);
        hopper_empty = 3'b000;
        amount       = 4'd7;
        load         = 1'b1;
        for (int j = 0; j < 20 && !hit; j++) begin
            @(negedge clk);
            load = 1'b0;
            if (eject != 3'b000) ej_seen++;
            if (ej_seen == 2) begin
                hit = 1'b1;
                #2 reset_n = 1'b0;
                #1;
                n_cmp++;
                if ({eject, ready, busy, done, remaining} !== {3'b000, 1'b1, 1'b0, 1'b0, 4'd0}) begin
                    n_err++;
                    $display("FAIL mid_reset_state: got eject=%b ready=%b busy=%b done=%b rem=%0d required 000 1 0 0 0",
                             eject, ready, busy, done, remaining);
                end
            end
        end
        n_cmp++;
        if (hit !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_reach: got %b required 1 (second eject cycle not seen)", hit);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (done || eject != 3'b000) stray_done++;
        end
        n_cmp++;
        if (stray_done !== 0) begin
            n_err++;
            $display("FAIL mid_reset_quiet: got %0d active cycles required 0", stray_done);
        end
        run_payout("t6_after_reset_amt1", 1, 3'b000, 3'b000, 1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int         amt;
        logic [2:0] empty;
        logic [2:0] dead;
        int         echo;
        bit         dbl;
        bit         bl;
        for (int i = 0; i < 30; i++) begin
            amt   = $urandom_range(0, 15);
            empty = 3'($urandom_range(0, 7));
            for (int b = 0; b < 3; b++) dead[b] = ($urandom_range(0, 3) == 0);
            echo  = $urandom_range(0, 12);
            dbl   = 1'($urandom_range(0, 1));
            bl    = 1'($urandom_range(0, 1));
            run_payout($sformatf("rand%0d_a%0d_e%b_d%b_s%0d", i, amt, empty, dead, echo),
                       amt, empty, dead, echo, dbl, bl);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_eject();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
